// File: rtl/matrix_pkg.sv
// Frame format shared by the matrix compiler (TX) and decompiler (RX):
// decoder states, preamble/SFD dibit values and default matrix geometry.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DRAIN
    } state_t;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_DIBIT      = 2'b11;

    localparam int DEFAULT_ROWS = 32;
    localparam int DEFAULT_COLS = 32;

endpackage

// File: rtl/matrix_decompiler_dibit_to_byte.sv
// Assembles four received dibits, least significant first, into one byte.
// byte_valid pulses for one cycle on the edge after the fourth dibit.
module dibit_to_byte (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_clear,
    input  logic       dibit_valid,
    input  logic [1:0] dibit,
    output logic [7:0] byte_data,
    output logic       byte_valid
);

    logic [1:0] phase;
    logic [5:0] partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (sync_clear) begin
                phase <= '0;
            end else if (dibit_valid) begin
                phase      <= phase + 2'd1;
                byte_valid <= (phase == 2'd3);
            end
        end
    end

    // Every slot is rewritten before use, so the shift data needs no reset.
    always_ff @(posedge clk) begin
        if (dibit_valid && !sync_clear) begin
            case (phase)
                2'd0:    partial[1:0] <= dibit;
                2'd1:    partial[3:2] <= dibit;
                2'd2:    partial[5:4] <= dibit;
                default: byte_data    <= {dibit, partial};
            endcase
        end
    end

endmodule

// File: rtl/matrix_decompiler.sv
// RX side of the matrix link: finds preamble/SFD in the RMII-style dibit
// stream and emits each reassembled byte with its row-major (row, col) tag.
module matrix_decompiler
    import matrix_pkg::*;
#(
    parameter  int ROWS         = DEFAULT_ROWS,
    parameter  int COLS         = DEFAULT_COLS,
    parameter  int PREAMBLE_MIN = 4,
    localparam int RW           = $clog2(ROWS),
    localparam int CW           = $clog2(COLS)
) (
    input  logic          eth_refclk,
    input  logic          rst_n,
    input  logic          valid_data_in,
    input  logic [1:0]    dibit,
    output logic          valid_data_out,
    output logic [RW-1:0] row_addr,
    output logic [CW-1:0] col_addr,
    output logic [7:0]    matrix_element,
    output logic          frame_done,
    output logic          frame_error
);

    localparam int            PW      = $clog2(PREAMBLE_MIN + 1);
    localparam logic [PW-1:0] PRE_SAT = PW'(PREAMBLE_MIN);

    state_t        state, state_next;
    logic [PW-1:0] pre_cnt, pre_cnt_next;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic          sync_clear, addr_clear, done_next, error_next;
    logic          payload_dibit, byte_valid, strobe, last_elem;
    logic [7:0]    byte_data;

    assign payload_dibit = (state == PAYLOAD) && valid_data_in;
    assign strobe        = (state == PAYLOAD) && byte_valid;
    assign last_elem     = (row_cnt == RW'(ROWS - 1)) && (col_cnt == CW'(COLS - 1));

    dibit_to_byte u_dibit_to_byte (
        .clk         (eth_refclk),
        .rst_n       (rst_n),
        .sync_clear  (sync_clear),
        .dibit_valid (payload_dibit),
        .dibit       (dibit),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid)
    );

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pre_cnt <= '0;
        end else begin
            state   <= state_next;
            pre_cnt <= pre_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        pre_cnt_next = pre_cnt;
        sync_clear   = 1'b0;
        addr_clear   = 1'b0;
        done_next    = 1'b0;
        error_next   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_data_in && dibit == PREAMBLE_DIBIT) begin
                    state_next   = PREAMBLE;
                    pre_cnt_next = PW'(1);
                end
            end
            PREAMBLE: begin
                if (!valid_data_in) begin
                    state_next   = IDLE;
                    pre_cnt_next = '0;
                end else if (dibit == PREAMBLE_DIBIT) begin
                    if (pre_cnt != PRE_SAT) pre_cnt_next = pre_cnt + PW'(1);
                end else if (dibit == SFD_DIBIT && pre_cnt >= PRE_SAT) begin
                    state_next   = PAYLOAD;
                    pre_cnt_next = '0;
                    sync_clear   = 1'b1;
                    addr_clear   = 1'b1;
                end else begin
                    state_next   = DRAIN;
                    pre_cnt_next = '0;
                    sync_clear   = 1'b1;
                    error_next   = 1'b1;
                end
            end
            PAYLOAD: begin
                // A byte still in flight when valid drops is emitted before deciding
                if (byte_valid && last_elem) begin
                    state_next = DRAIN;
                    sync_clear = 1'b1;
                    done_next  = 1'b1;
                end else if (!valid_data_in) begin
                    state_next = IDLE;
                    sync_clear = 1'b1;
                    error_next = 1'b1;
                end
            end
            DRAIN: begin
                if (!valid_data_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (addr_clear) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (strobe) begin
            if (col_cnt == CW'(COLS - 1)) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge eth_refclk or negedge rst_n) begin
        if (!rst_n) begin
            valid_data_out <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            row_addr       <= '0;
            col_addr       <= '0;
            matrix_element <= '0;
        end else begin
            valid_data_out <= strobe;
            frame_done     <= done_next;
            frame_error    <= error_next;
            if (strobe) begin
                row_addr       <= row_cnt;
                col_addr       <= col_cnt;
                matrix_element <= byte_data;
            end
        end
    end

endmodule
